voice_mixer: RTL
================

# voice_mixer

Parametrised N-voice sample mixer for the synthesizer datapath. It collects one signed sample per enabled voice (note players) for each codec sample period and sums them in a time-multiplexed accumulator. The sum gets optional attenuation and saturation, and is presented as one registered sample with a one-cycle ready strobe for the codec conditioner. It replaces ad-hoc wrapping adders: clipping is detected, voices that never deliver are flagged, and channel count and width are generic.

## Interface
- NUM_VOICES, 3, number of voice inputs (1..16)
- SAMPLE_WIDTH, 16, two's-complement sample width (W)
- WAIT_LIMIT, 255, maximum cycles spent waiting for voice samples after a trigger

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- generate_next_sample  in  1  one-cycle strobe; starts one mix frame
- voice_enable  in  NUM_VOICES  per-voice enable; snapshotted at trigger
- voice_samples  in  NUM_VOICES*W  flat bus; voice i at [i*W +: W], signed
- voice_ready  in  NUM_VOICES  per-voice one-cycle strobe; sample valid
- attenuate  in  2  arithmetic right shift (0..3) applied to the sum before saturation; sampled in EMIT
- sample_out  out  W  mixed signed sample, registered; reset 0
- sample_ready  out  1  one-cycle pulse, sample_out valid; reset 0
- clip  out  1  high with sample_ready if saturation occurred; else 0; reset 0
- missed  out  NUM_VOICES  enabled voices that timed out this frame; updated with sample_ready, held otherwise; reset 0

## Operation
- Per voice i: hold[i] (W bits) and fresh[i].
  - voice_ready[i] high: hold[i] <= sample and fresh[i] <= 1. This capture happens in every state.
- Accumulator acc is W+clog2(NUM_VOICES)+1 bits signed. Voice samples are sign-extended; the accumulator never wraps.
- FSM states: IDLE, WAIT, ACCUM, EMIT.
- IDLE
  - On generate_next_sample: en_q <= voice_enable, wait counter <= 0, go to WAIT.
- WAIT
  - Exit condition: (fresh & en_q) == en_q, or counter == WAIT_LIMIT.
  - On exit: missed_q <= en_q & ~fresh, acc <= 0, idx <= 0, go to ACCUM.
  - Otherwise counter++.
- ACCUM, one voice per cycle:
  - acc += en_q[idx] ? sext(hold[idx]) : 0.
  - fresh[idx] cleared, unless voice_ready[idx] is high the same cycle. In that case the old hold value is summed, and the new one is kept with fresh = 1.
  - After idx == NUM_VOICES-1, go to EMIT.
- A missed voice contributes its stale hold value, not zero. This avoids clicks. A voice that has never delivered contributes 0.
- Disabled voices contribute 0.
- EMIT
  - s = acc >>> attenuate.
  - Saturate s to [-2^(W-1), 2^(W-1)-1].
  - Register sample_out, clip and missed; pulse sample_ready; return to IDLE.
- generate_next_sample is ignored while not in IDLE: no queueing, no second frame.
- voice_enable changes mid-frame have no effect until the next trigger.

## Timing
- Trigger high in cycle 0 → WAIT in cycle 1.
- If all enabled voices are fresh in cycle 1, the frame proceeds without waiting:
  - ACCUM in cycles 2..NUM_VOICES+1.
  - EMIT in cycle NUM_VOICES+2.
  - sample_ready high in cycle NUM_VOICES+3 (cycle 6 for 3 voices).
- Each additional WAIT cycle adds one cycle of latency. Worst case, sample_ready is high in cycle NUM_VOICES+3+WAIT_LIMIT.
- sample_ready is high for exactly one cycle per accepted trigger.
- sample_out holds its value until the next sample_ready.
- Reset at any point, including mid-frame:
  - State, hold, fresh and acc are cleared.
  - All outputs go to 0 immediately (asynchronous).
  - No sample_ready is issued for the aborted frame.
- Back-to-back: a trigger in the cycle sample_ready is high is accepted, because the FSM is already in IDLE.

## Test plan
- Sum without saturation
  - Stimulus: NUM_VOICES=3, W=16. Ready strobes with samples 1000, 2000, 3000. attenuate=0. Trigger in cycle 0.
  - Required: sample_ready only in cycle 6, sample_out=6000, clip=0, missed=000.
- Saturation, both rails
  - Stimulus: samples 30000, 10000, 0.
  - Required: sample_out=32767, clip=1.
  - Stimulus: samples -30000, -10000, -5000.
  - Required: sample_out=-32768, clip=1.
- Attenuation
  - Stimulus: attenuate=2, samples 30000 ×3.
  - Required: 90000>>>2 = 22500, clip=0.
  - Stimulus: attenuate=1, samples -3, 0, 0.
  - Required: sample_out=-2 (arithmetic shift).
- Timeout
  - Stimulus: WAIT_LIMIT=15. Voice 2 previously delivered 500, then stays silent. Voices 0 and 1 give 100 and 200.
  - Required: sample_ready in cycle 21, sample_out=800, missed=100.
- Enable mask and overlapping trigger
  - Stimulus: voice_enable=010, samples 7, 9, 11. Second trigger in cycle 3.
  - Required: a single sample_ready with sample_out=9, and no second frame.
- Reset mid-frame
  - Stimulus: assert reset during ACCUM, release, then run the scenario-1 stimulus again.
  - Required: outputs read 0 while reset is high, and no sample_ready follows the aborted frame. After release, the scenario-1 stimulus gives sample_out=6000.

Source files
------------

// File: rtl/voice_mixer.sv
// N-voice sample mixer: collects one sample per enabled voice, sums, attenuates and saturates.
// Latency: sample_ready NUM_VOICES+3 cycles after trigger, plus one cycle per extra WAIT cycle (max WAIT_LIMIT).
// Backpressure: none; triggers arriving outside IDLE are dropped, voice strobes are captured in every state.
module voice_mixer #(
   parameter int NUM_VOICES   = 3,
   parameter int SAMPLE_WIDTH = 16,
   parameter int WAIT_LIMIT   = 255
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               generate_next_sample,
   input  logic [NUM_VOICES-1:0]              voice_enable,
   input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
   input  logic [NUM_VOICES-1:0]              voice_ready,
   input  logic [1:0]                         attenuate,
   output logic [SAMPLE_WIDTH-1:0]            sample_out,
   output logic                               sample_ready,
   output logic                               clip,
   output logic [NUM_VOICES-1:0]              missed
);

   localparam int W     = SAMPLE_WIDTH;
   // Headroom of clog2(N)+1 bits means the running sum can never wrap.
   localparam int ACC_W = W + $clog2(NUM_VOICES) + 1;
   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

   // Saturation rails expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCUM, ST_EMIT} state_t;

   state_t                   state_q, state_d;
   logic [NUM_VOICES-1:0]    en_q, en_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [W-1:0]             hold_q [NUM_VOICES];
   logic [W-1:0]             hold_d [NUM_VOICES];
   logic [NUM_VOICES-1:0]    fresh_q, fresh_d;
   logic [NUM_VOICES-1:0]    miss_frame_q, miss_frame_d;
   logic [W-1:0]             sample_out_q, sample_out_d;
   logic                     sample_ready_q, sample_ready_d;
   logic                     clip_q, clip_d;
   logic [NUM_VOICES-1:0]    missed_q, missed_d;

   logic [W-1:0]             cur_hold;
   logic signed [ACC_W-1:0]  acc_term;
   logic signed [ACC_W-1:0]  shifted;

   // Sign-extended contribution of the voice selected by idx (zero when disabled) and the attenuated sum.
   always_comb begin
      cur_hold = hold_q[idx_q];
      acc_term = '0;
      if (en_q[idx_q]) begin
         acc_term = {{(ACC_W-W){cur_hold[W-1]}}, cur_hold};
      end
      shifted = acc_q >>> attenuate;
   end

   // Next-state logic: FSM sequencing, accumulation, saturation and voice capture.
   always_comb begin
      state_d        = state_q;
      en_d           = en_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      acc_d          = acc_q;
      hold_d         = hold_q;
      fresh_d        = fresh_q;
      miss_frame_d   = miss_frame_q;
      sample_out_d   = sample_out_q;
      sample_ready_d = 1'b0;
      clip_d         = 1'b0;
      missed_d       = missed_q;

      case (state_q)
         ST_IDLE: begin
            if (generate_next_sample) begin
               en_d    = voice_enable;
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (((fresh_q & en_q) == en_q) || (cnt_q == CNT_W'(WAIT_LIMIT))) begin
               miss_frame_d = en_q & ~fresh_q;
               acc_d        = '0;
               idx_d        = '0;
               state_d      = ST_ACCUM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ACCUM: begin
            acc_d          = acc_q + acc_term;
            fresh_d[idx_q] = 1'b0;
            if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
               state_d = ST_EMIT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_EMIT: begin
            if (shifted > SAT_MAX) begin
               sample_out_d = {1'b0, {(W-1){1'b1}}};
               clip_d       = 1'b1;
            end else if (shifted < SAT_MIN) begin
               sample_out_d = {1'b1, {(W-1){1'b0}}};
               clip_d       = 1'b1;
            end else begin
               sample_out_d = shifted[W-1:0];
            end
            missed_d       = miss_frame_q;
            sample_ready_d = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A strobe always wins: it overrides the ACCUM clear so a sample arriving mid-sum is kept for next frame.
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (voice_ready[i]) begin
            hold_d[i]  = voice_samples[i*W +: W];
            fresh_d[i] = 1'b1;
         end
      end
   end

   // State and output registers; reset aborts any frame and clears outputs immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         en_q           <= '0;
         cnt_q          <= '0;
         idx_q          <= '0;
         acc_q          <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            hold_q[i] <= '0;
         end
         fresh_q        <= '0;
         miss_frame_q   <= '0;
         sample_out_q   <= '0;
         sample_ready_q <= 1'b0;
         clip_q         <= 1'b0;
         missed_q       <= '0;
      end else begin
         state_q        <= state_d;
         en_q           <= en_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         acc_q          <= acc_d;
         hold_q         <= hold_d;
         fresh_q        <= fresh_d;
         miss_frame_q   <= miss_frame_d;
         sample_out_q   <= sample_out_d;
         sample_ready_q <= sample_ready_d;
         clip_q         <= clip_d;
         missed_q       <= missed_d;
      end
   end

   assign sample_out   = sample_out_q;
   assign sample_ready = sample_ready_q;
   assign clip         = clip_q;
   assign missed       = missed_q;

endmodule
